// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: sequential PCs, in-order requests, instruction queue
module fetch_unit #(
  parameter int unsigned QDEPTH   = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic [3:0]  opcode,
  output logic [5:0]  funct,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        halted
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam logic [CW:0] QDEPTH_C = (CW + 1)'(QDEPTH);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]  occ_q, occ_d;
  logic [CW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  drop_q, drop_d;
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [PW-1:0]  iwr_q, iwr_d;
  logic [PW-1:0]  ird_q, ird_d;

  // Instruction queue entries and the PCs of granted-but-unreturned fetches.
  logic [15:0]    q_pc_q   [QDEPTH];
  logic [15:0]    q_word_q [QDEPTH];
  logic [15:0]    ipc_q    [QDEPTH];

  logic           grant;
  logic           rv;
  logic           rv_drop;
  logic           push;
  logic           pop;
  logic           room;
  logic [CW:0]    reserved;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(QDEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign inst_valid = reset_n & (occ_q != '0);
  assign inst       = inst_valid ? q_word_q[head_q] : 16'h0000;
  assign inst_pc    = inst_valid ? q_pc_q[head_q]   : 16'h0000;
  assign opcode     = inst[15:12];
  assign funct      = inst[5:0];

  // A head leaving this cycle frees its slot, so steady streaming needs no bubble.
  assign pop      = inst_valid & inst_ready & ~redirect;
  assign reserved = {1'b0, occ_q} + {1'b0, inflight_q} - {{CW{1'b0}}, pop};
  assign room     = reserved < QDEPTH_C;

  // Returns with nothing outstanding (leftovers from before a reset) are ignored.
  assign rv       = mem_rvalid & (inflight_q != '0);
  assign rv_drop  = rv & (drop_q != '0);
  assign push     = rv & ~rv_drop & ~redirect;
  assign grant    = mem_req & mem_gnt;
  assign mem_addr = mem_req ? fetch_pc_q : 16'h0000;

  // FSM next state and the request/halted outputs.
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    halted  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = reset_n & ~redirect & room;
        if (halt) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        halted = reset_n;
      end
    endcase
  end

  // Datapath next state: PC advance, pointer/counter updates, redirect flush.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    iwr_d      = iwr_q;
    ird_d      = ird_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CW'(grant) - CW'(rv);
    occ_d      = occ_q + CW'(push) - CW'(pop);

    if (grant) begin
      fetch_pc_d = fetch_pc_q + 16'd1;
      iwr_d      = ptr_inc(iwr_q);
    end
    if (rv) begin
      ird_d = ptr_inc(ird_q);
    end
    if (rv_drop) begin
      drop_d = drop_q - CW'(1);
    end
    if (push) begin
      tail_d = ptr_inc(tail_q);
    end
    if (pop) begin
      head_d = ptr_inc(head_q);
    end

    // Everything still outstanding after this cycle belongs to the old path.
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      occ_d      = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_d     = inflight_q - CW'(rv);
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      occ_q      <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      iwr_q      <= '0;
      ird_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      iwr_q      <= iwr_d;
      ird_q      <= ird_d;
    end
  end

  // Storage: record the PC at grant, then pair it with the returned word at push.
  always_ff @(posedge clk) begin
    if (grant) begin
      ipc_q[iwr_q] <= fetch_pc_q;
    end
    if (push) begin
      q_pc_q[tail_q]   <= ipc_q[ird_q];
      q_word_q[tail_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with randomized memory and decode
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int          QD  = 2;
  localparam logic [15:0] RPC = 16'h0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [15:0] mem_addr, mem_rdata;
  logic        inst_valid, inst_ready, redirect, halt, halted;
  logic [15:0] inst, inst_pc, redirect_pc;
  logic [3:0]  opcode;
  logic [5:0]  funct;

  fetch_unit #(.QDEPTH(QD), .RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .opcode(opcode), .funct(funct), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted)
  );

  // Second instance starting just below the 16-bit wrap point.
  logic        w_req, w_rvalid, w_valid, w_halted;
  logic [15:0] w_addr, w_rdata, w_inst, w_pc;
  logic [3:0]  w_op;
  logic [5:0]  w_fn;

  fetch_unit #(.QDEPTH(QD), .RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .reset_n(reset_n),
    .mem_req(w_req), .mem_addr(w_addr), .mem_gnt(1'b1),
    .mem_rvalid(w_rvalid), .mem_rdata(w_rdata),
    .inst_valid(w_valid), .inst(w_inst), .inst_pc(w_pc),
    .opcode(w_op), .funct(w_fn), .inst_ready(1'b1),
    .redirect(1'b0), .redirect_pc(16'h0000),
    .halt(1'b0), .halted(w_halted)
  );

  typedef struct { logic [15:0] addr; int due; } pend_t;
  typedef struct { logic [15:0] pc; logic [15:0] word; } exp_t;

  pend_t       pend[$];
  exp_t        expq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_due = 0;
  int          lat      = 1;
  int          gnt_pct  = 100;
  int          outstanding = 0;
  int          grants   = 0;
  int          pops     = 0;
  int          wk       = 0;
  logic        rand_lat = 1'b0;
  logic        rst_req  = 1'b1;
  logic [15:0] seg_pc   = RPC;
  logic        halted_exp = 1'b0;
  logic        halted_nxt = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic restart_stream(input logic [15:0] pc);
    expq.delete();
    seg_pc = pc;
  endtask

  // Reference: decode sees consecutive PCs from the last reset/redirect target.
  task automatic top_up();
    exp_t e;
    while (expq.size() < 16) begin
      e.pc   = seg_pc;
      e.word = seg_pc ^ 16'hA000;
      expq.push_back(e);
      seg_pc = seg_pc + 16'd1;
    end
  endtask

  task automatic tick(input logic rdy, input logic redir, input logic [15:0] rpc, input logic hlt);
    pend_t p;
    @(negedge clk);
    cyc++;
    reset_n    = ~rst_req;
    halted_exp = reset_n ? halted_nxt : 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0000;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = p.addr ^ 16'hA000;
      outstanding--;
    end
    mem_gnt     = (int'($urandom_range(0, 99)) < gnt_pct);
    inst_ready  = rdy;
    redirect    = redir & reset_n;
    redirect_pc = rpc;
    halt        = hlt & reset_n;
    if (redirect) restart_stream(rpc);
    top_up();
    #1;
    if (reset_n && mem_req && mem_gnt) begin
      p.addr = mem_addr;
      p.due  = cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat);
      if (p.due <= last_due) p.due = last_due + 1;
      last_due = p.due;
      pend.push_back(p);
      outstanding++;
      grants++;
    end
    halted_nxt = reset_n & (halted_exp | halt);
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    pend.delete();
    outstanding = 0;
    repeat (3) tick(1'b0, 1'b0, 16'h0000, 1'b0);
    check("rst_mem_req",    32'(mem_req),    32'd0);
    check("rst_mem_addr",   32'(mem_addr),   32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst",       32'(inst),       32'd0);
    check("rst_inst_pc",    32'(inst_pc),    32'd0);
    check("rst_opcode",     32'(opcode),     32'd0);
    check("rst_funct",      32'(funct),      32'd0);
    check("rst_halted",     32'(halted),     32'd0);
    rst_req = 1'b0;
    grants  = 0;
    restart_stream(RPC);
  endtask

  // Monitor: scoreboard pops on every accepted instruction plus per-cycle invariants.
  logic        pv = 1'b0, pr = 1'b0, prd = 1'b0, prst = 1'b0;
  logic [15:0] ppc = 16'h0, pinst = 16'h0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n) begin
        check("halted", 32'(halted), 32'(halted_exp));
        if (halted_exp || redirect) check("req_blocked", 32'(mem_req), 32'd0);
        check("outstanding_cap", 32'(outstanding <= QD), 32'd1);
        if (prst && pv && !pr && !prd) begin
          check("bp_valid", 32'(inst_valid), 32'd1);
          check("bp_pc",    32'(inst_pc),    32'(ppc));
          check("bp_inst",  32'(inst),       32'(pinst));
        end
        if (inst_valid && inst_ready && !redirect) begin
          pops++;
          n_checks++;
          if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: got pc %h, expected no instruction", inst_pc);
          end else begin
            e = expq.pop_front();
            check("sb_pc",     32'(inst_pc), 32'(e.pc));
            check("sb_inst",   32'(inst),    32'(e.word));
            check("sb_opcode", 32'(opcode),  32'(e.word[15:12]));
            check("sb_funct",  32'(funct),   32'(e.word[5:0]));
          end
        end
      end
      pv = inst_valid; pr = inst_ready; prd = redirect; prst = reset_n;
      ppc = inst_pc; pinst = inst;
    end
  end

  // Zero-wait memory and checker for the wrap-around instance.
  logic        w_pend = 1'b0;
  logic [15:0] w_paddr = 16'h0;
  initial begin
    logic [15:0] wexp;
    w_rvalid = 1'b0;
    w_rdata  = 16'h0;
    forever begin
      @(negedge clk);
      w_rvalid = w_pend;
      w_rdata  = w_paddr ^ 16'hA000;
      #1;
      w_pend  = reset_n & w_req;
      w_paddr = w_addr;
      #1;
      if (reset_n && w_valid && wk < 4) begin
        wexp = 16'hFFFE + 16'(wk);
        check("wrap_pc",   32'(w_pc),   32'(wexp));
        check("wrap_inst", 32'(w_inst), 32'(wexp ^ 16'hA000));
        wk++;
      end
    end
  end

  initial begin
    int t;
    int p0;
    reset_n = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0;
    inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; halt = 1'b0;

    // Zero-wait streaming after reset release.
    gnt_pct = 100; lat = 1; rand_lat = 1'b0;
    do_reset();
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    check("b_valid_c0", 32'(inst_valid), 32'd0);
    check("b_req_c0",   32'(mem_req),    32'd1);
    check("b_addr_c0",  32'(mem_addr),   32'(RPC));
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    check("b_valid_c1", 32'(inst_valid), 32'd0);
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    check("b_valid_c2", 32'(inst_valid), 32'd1);
    repeat (12) begin
      tick(1'b1, 1'b0, 16'h0, 1'b0);
      check("b_no_bubble", 32'(inst_valid), 32'd1);
    end

    // Backpressure from the first valid for six cycles.
    do_reset();
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    t = 0;
    while (!inst_valid && t < 20) begin
      tick(1'b0, 1'b0, 16'h0, 1'b0);
      t++;
    end
    check("c_first_valid", 32'(inst_valid), 32'd1);
    repeat (6) tick(1'b0, 1'b0, 16'h0, 1'b0);
    check("c_grants",  32'(grants),  32'd2);
    check("c_req_low", 32'(mem_req), 32'd0);
    check("c_head_pc", 32'(inst_pc), 32'(RPC));
    repeat (10) tick(1'b1, 1'b0, 16'h0, 1'b0);

    // Redirect with two fetches in flight on a 3-cycle memory.
    do_reset();
    lat = 3;
    repeat (2) tick(1'b1, 1'b0, 16'h0, 1'b0);
    check("d_two_inflight", 32'(outstanding), 32'd2);
    tick(1'b1, 1'b1, 16'h0040, 1'b0);
    p0 = pops;
    repeat (15) tick(1'b1, 1'b0, 16'h0, 1'b0);
    check("d_progress", 32'((pops - p0) >= 3), 32'd1);

    // Redirect coincident with a return and a pop on zero-wait memory.
    do_reset();
    lat = 1;
    repeat (6) tick(1'b1, 1'b0, 16'h0, 1'b0);
    tick(1'b1, 1'b1, 16'h1234, 1'b0);
    check("e_pop_pre",  32'(inst_valid), 32'd1);
    check("e_req_redir", 32'(mem_req),   32'd0);
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    check("e_flushed",   32'(inst_valid), 32'd0);
    check("e_req_after", 32'(mem_req),    32'd1);
    check("e_addr_after", 32'(mem_addr),  32'h1234);
    repeat (8) tick(1'b1, 1'b0, 16'h0, 1'b0);

    // Halt with one fetch in flight, then redirect while halted, then reset.
    do_reset();
    lat = 3; gnt_pct = 100;
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    gnt_pct = 0;
    tick(1'b1, 1'b0, 16'h0, 1'b1);
    p0 = pops;
    gnt_pct = 100;
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    check("f_halted",  32'(halted),  32'd1);
    check("f_req_low", 32'(mem_req), 32'd0);
    repeat (8) tick(1'b1, 1'b0, 16'h0, 1'b0);
    check("f_grants", 32'(grants), 32'd1);
    check("f_drained", 32'(pops - p0), 32'd1);
    tick(1'b1, 1'b1, 16'h0100, 1'b0);
    repeat (4) tick(1'b1, 1'b0, 16'h0, 1'b0);
    check("f_still_halted", 32'(halted), 32'd1);
    do_reset();
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    check("f_restart_req",  32'(mem_req),  32'd1);
    check("f_restart_addr", 32'(mem_addr), 32'(RPC));
    check("f_restart_halt", 32'(halted),   32'd0);
    repeat (4) tick(1'b1, 1'b0, 16'h0, 1'b0);

    // Random latency, grants, backpressure and redirects, with a mid-run reset.
    rand_lat = 1'b1; gnt_pct = 70;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      tick(int'($urandom_range(0, 99)) < 70,
           int'($urandom_range(0, 99)) < 4,
           16'($urandom), 1'b0);
    end
    repeat (10) tick(1'b1, 1'b0, 16'h0, 1'b0);

    check("wrap_count", 32'(wk), 32'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
